// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention context block.
package attn_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Wide enough to hold any rounded accumulator before clamping.
    localparam int SAT_W = 128;

    // Half an LSB of the output format; added before the arithmetic shift.
    function automatic logic [63:0] round_const(input int fbits);
        return 64'd1 << (fbits - 1);
    endfunction

    // Clamp a wide signed value to the range of a width-bit signed word.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] x,
                                                         input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (128'sd1 <<< (width - 1)) - 128'sd1;
        lo = ~hi;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/attn_context_fx_mac.sv
// Full-precision signed multiply-accumulate with synchronous clear.
module fx_mac #(
    parameter int WIDTH = 32,
    parameter int AW    = 66
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [AW-1:0]    sum
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      acc;

    // The product keeps all 2*WIDTH bits; sum is what the accumulator becomes this cycle.
    assign prod = a * b;
    assign sum  = acc + AW'(prod);

    // Accumulator: clear has priority so the final term can be consumed and dropped in one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/attn_context.sv
// Context vector: Ctx[d] = sum_n P[n]*V[n][d], one product per cycle, rounded and saturated.
module attn_context
    import attn_pkg::*;
#(
    parameter int N     = 4,
    parameter int D     = 4,
    parameter int WIDTH = 32,
    parameter int FBITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] P   [N-1:0],
    input  logic signed [WIDTH-1:0] V   [N-1:0][D-1:0],
    output logic signed [WIDTH-1:0] Ctx [D-1:0],
    output logic                    busy,
    output logic                    done
);

    localparam int AW = 2 * WIDTH + $clog2(N);
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = (D > 1) ? $clog2(D) : 1;
    localparam logic [NW-1:0]       N_LAST = NW'(N - 1);
    localparam logic [DW-1:0]       D_LAST = DW'(D - 1);
    localparam logic signed [AW:0]  RND    = (AW + 1)'(round_const(FBITS));

    state_t                  state;
    state_t                  state_nx;
    logic [NW-1:0]           n;
    logic [DW-1:0]           d;
    logic signed [WIDTH-1:0] p_lat [N-1:0];
    logic signed [WIDTH-1:0] v_lat [N-1:0][D-1:0];
    logic signed [AW-1:0]    sum;
    logic signed [AW:0]      rnd;
    logic signed [WIDTH-1:0] ctx_nx;
    logic                    accept;
    logic                    last_n;
    logic                    last_d;
    logic                    mac_en;
    logic                    mac_clr;

    assign busy    = (state != S_IDLE);
    assign accept  = (state == S_IDLE) && start;
    assign last_n  = (n == N_LAST);
    assign last_d  = (d == D_LAST);
    assign mac_en  = (state == S_MAC);
    assign mac_clr = accept || (mac_en && last_n);

    // One extra bit so adding half an LSB cannot wrap before the shift.
    assign rnd    = ($signed({sum[AW-1], sum}) + RND) >>> FBITS;
    assign ctx_nx = WIDTH'(saturate(SAT_W'(rnd), WIDTH));

    fx_mac #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (p_lat[n]),
        .b   (v_lat[n][d]),
        .sum (sum)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic: start is only looked at in IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_MAC;
            S_MAC:   if (last_n && last_d) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand capture, loop counters, result write-back and the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n    <= '0;
            d    <= '0;
            done <= 1'b0;
            for (int i = 0; i < D; i++)
                Ctx[i] <= '0;
            for (int i = 0; i < N; i++) begin
                p_lat[i] <= '0;
                for (int j = 0; j < D; j++)
                    v_lat[i][j] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        p_lat <= P;
                        v_lat <= V;
                        n     <= '0;
                        d     <= '0;
                    end
                end
                S_MAC: begin
                    if (last_n) begin
                        Ctx[d] <= ctx_nx;
                        n      <= '0;
                        d      <= d + DW'(1);
                        if (last_d)
                            done <= 1'b1;
                    end else begin
                        n <= n + NW'(1);
                    end
                end
                default: done <= 1'b0;
            endcase
        end
    end

endmodule
